// File: rtl/teclado_cajero.sv
// Keypad front end for the ATM controller: synchronizes and debounces the raw
// keypad, then turns each accepted press into PIN digit or amount strobes.
module teclado_cajero #(
  parameter int DEBOUNCE_CICLOS = 16,
  parameter int ANCHO_MONTO     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tecla_activa,
  input  logic [3:0]             tecla_codigo,
  input  logic                   modo_monto,
  output logic [3:0]             digito,
  output logic                   digito_stb,
  output logic [ANCHO_MONTO-1:0] monto,
  output logic                   monto_stb,
  output logic                   desborde
);

  localparam int CW = (DEBOUNCE_CICLOS < 2) ? 1 : $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] CNT_UNO = CW'(1);
  localparam logic [CW-1:0] CNT_FIN = CW'(DEBOUNCE_CICLOS);
  // With a one-cycle filter the initial load of 1 already completes it.
  localparam bit UN_CICLO = (DEBOUNCE_CICLOS <= 1);

  localparam logic [3:0] COD_ENTER = 4'hA;
  localparam logic [3:0] COD_CLEAR = 4'hB;

  typedef enum logic [1:0] {
    ESPERA,
    FILTRO_P,
    PRESIONADA,
    FILTRO_L
  } estado_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers for the asynchronous keypad lines
  // ---------------------------------------------------------------------------
  logic       tec_m, tec_s;
  logic [3:0] cod_m, cod_s;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its sources, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tec_m <= 1'b0;
      tec_s <= 1'b0;
      cod_m <= 4'h0;
      cod_s <= 4'h0;
    end else begin
      tec_m <= tecla_activa;
      tec_s <= tec_m;
      cod_m <= tecla_codigo;
      cod_s <= cod_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  estado_t       estado_q, estado_d;
  logic [CW-1:0] cont_q, cont_d, cont_inc;
  logic [3:0]    cod_ref_q, cod_ref_d;
  logic          acepta_d;
  logic          acepta_q;
  logic [3:0]    tecla_q;

  assign cont_inc = cont_q + CNT_UNO;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    estado_d  = estado_q;
    cont_d    = cont_q;
    cod_ref_d = cod_ref_q;
    acepta_d  = 1'b0;
    unique case (estado_q)
      ESPERA: begin
        if (tec_s) begin
          cont_d    = CNT_UNO;
          cod_ref_d = cod_s;
          if (UN_CICLO) begin
            acepta_d = 1'b1;
            estado_d = PRESIONADA;
          end else begin
            estado_d = FILTRO_P;
          end
        end
      end
      FILTRO_P: begin
        if (!tec_s) begin
          estado_d = ESPERA;
        end else if (cod_s != cod_ref_q) begin
          cod_ref_d = cod_s;
          cont_d    = CNT_UNO;
        end else begin
          cont_d = cont_inc;
          if (cont_inc == CNT_FIN) begin
            acepta_d = 1'b1;
            estado_d = PRESIONADA;
          end
        end
      end
      PRESIONADA: begin
        if (!tec_s) begin
          cont_d   = CNT_UNO;
          estado_d = UN_CICLO ? ESPERA : FILTRO_L;
        end
      end
      FILTRO_L: begin
        if (tec_s) begin
          estado_d = PRESIONADA;
        end else begin
          cont_d = cont_inc;
          if (cont_inc == CNT_FIN) estado_d = ESPERA;
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= ESPERA;
      cont_q    <= '0;
      cod_ref_q <= 4'h0;
      acepta_q  <= 1'b0;
      tecla_q   <= 4'h0;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      cod_ref_q <= cod_ref_d;
      acepta_q  <= acepta_d;
      if (acepta_d) tecla_q <= cod_ref_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Key decode, amount accumulator and output strobes
  // ---------------------------------------------------------------------------
  logic [ANCHO_MONTO-1:0] acc_q;
  logic [ANCHO_MONTO+3:0] acc_ext, producto;
  logic                   modo_q, cambio_modo, es_digito, excede;

  // acc*10 + code never needs more than four extra bits.
  assign acc_ext     = {4'b0000, acc_q};
  assign producto    = (acc_ext << 3) + (acc_ext << 1) + {{ANCHO_MONTO{1'b0}}, tecla_q};
  assign excede      = |producto[ANCHO_MONTO+3:ANCHO_MONTO];
  assign es_digito   = (tecla_q <= 4'd9);
  assign cambio_modo = modo_monto ^ modo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      modo_q     <= 1'b0;
      acc_q      <= '0;
      digito     <= 4'h0;
      digito_stb <= 1'b0;
      monto      <= '0;
      monto_stb  <= 1'b0;
      desborde   <= 1'b0;
    end else begin
      modo_q     <= modo_monto;
      digito_stb <= 1'b0;
      monto_stb  <= 1'b0;
      // A mode switch abandons any partial entry and swallows a coincident key.
      if (cambio_modo) begin
        acc_q    <= '0;
        desborde <= 1'b0;
      end else if (acepta_q) begin
        if (!modo_q) begin
          if (es_digito) begin
            digito     <= tecla_q;
            digito_stb <= 1'b1;
          end
        end else if (es_digito) begin
          if (excede) desborde <= 1'b1;
          else        acc_q    <= producto[ANCHO_MONTO-1:0];
        end else if (tecla_q == COD_ENTER) begin
          if (!desborde) begin
            monto     <= acc_q;
            monto_stb <= 1'b1;
          end
          acc_q    <= '0;
          desborde <= 1'b0;
        end else if (tecla_q == COD_CLEAR) begin
          acc_q    <= '0;
          desborde <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_teclado_cajero.sv
// Self-checking bench for teclado_cajero: a key-event table plus hand-timed
// sequences, with strobes matched against a queue of expected events.
`timescale 1ns/1ps
module tb_teclado_cajero;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tecla_activa = 1'b0;
  logic [3:0]  tecla_codigo = 4'h0;
  logic        modo_monto = 1'b0;
  logic [3:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic        desborde;

  teclado_cajero #(.DEBOUNCE_CICLOS(D), .ANCHO_MONTO(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .tecla_activa (tecla_activa),
    .tecla_codigo (tecla_codigo),
    .modo_monto   (modo_monto),
    .digito       (digito),
    .digito_stb   (digito_stb),
    .monto        (monto),
    .monto_stb    (monto_stb),
    .desborde     (desborde)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_NADA, EV_DIG, EV_MON} ev_t;

  typedef struct {
    logic        modo;
    logic [3:0]  cod;
    ev_t         ev;
    logic [31:0] valor;
    logic        desb;
  } vec_t;

  typedef struct {
    logic        es_monto;
    logic [31:0] valor;
  } esperado_t;

  vec_t      tabla[$];
  esperado_t sb[$];
  int        n_vec = 0;
  int        n_err = 0;
  logic      prev_stb = 1'b0;

  task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] requerido);
    n_vec++;
    if (actual !== requerido) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               nombre, actual, actual, requerido, requerido, $time);
    end
  endtask

  task automatic esperar(input logic es_monto, input logic [31:0] valor);
    esperado_t e;
    e.es_monto = es_monto;
    e.valor    = valor;
    sb.push_back(e);
  endtask

  task automatic agregar(input logic m, input logic [3:0] c, input ev_t e,
                         input logic [31:0] val, input logic d);
    vec_t v;
    v.modo = m; v.cod = c; v.ev = e; v.valor = val; v.desb = d;
    tabla.push_back(v);
  endtask

  task automatic pulsar(input logic [3:0] c);
    @(negedge clk);
    tecla_codigo = c;
    tecla_activa = 1'b1;
    repeat (D + 8) @(negedge clk);
    tecla_activa = 1'b0;
    repeat (D + 8) @(negedge clk);
  endtask

  // Scoreboard: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (reset) begin
      prev_stb = 1'b0;
    end else begin
      if (digito_stb || monto_stb) begin
        check("stb_exclusive", {31'b0, digito_stb & monto_stb}, 32'd0);
        check("stb_back_to_back", {31'b0, prev_stb}, 32'd0);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe: digito_stb=%0b monto_stb=%0b digito=%0d monto=%0d, expected none at %0t",
                   digito_stb, monto_stb, digito, monto, $time);
        end else begin
          esperado_t e;
          e = sb.pop_front();
          check("strobe_kind", {31'b0, monto_stb}, {31'b0, e.es_monto});
          check("strobe_value", monto_stb ? monto : {28'b0, digito}, e.valor);
        end
      end
      prev_stb = digito_stb | monto_stb;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Key table: PIN entries, then amount entries.
    agregar(0, 4'h0, EV_DIG, 0, 0);
    agregar(0, 4'hA, EV_NADA, 0, 0);
    agregar(0, 4'hC, EV_NADA, 0, 0);
    agregar(0, 4'h9, EV_DIG, 9, 0);
    agregar(0, 4'h2, EV_DIG, 2, 0);
    agregar(1, 4'h1, EV_NADA, 0, 0);
    agregar(1, 4'h2, EV_NADA, 0, 0);
    agregar(1, 4'h5, EV_NADA, 0, 0);
    agregar(1, 4'h0, EV_NADA, 0, 0);
    agregar(1, 4'hA, EV_MON, 1250, 0);
    agregar(1, 4'hA, EV_MON, 0, 0);
    agregar(1, 4'hD, EV_NADA, 0, 0);
    foreach (tabla[i]) begin end
    begin
      logic [3:0] mx [10] = '{4, 2, 9, 4, 9, 6, 7, 2, 9, 5};
      for (int i = 0; i < 10; i++) agregar(1, mx[i], EV_NADA, 0, 0);
      agregar(1, 4'hA, EV_MON, 32'hFFFF_FFFF, 0);
      for (int i = 0; i < 9; i++) agregar(1, mx[i], EV_NADA, 0, 0);
      agregar(1, 4'h6, EV_NADA, 0, 1);
      agregar(1, 4'h1, EV_NADA, 0, 1);
      agregar(1, 4'hA, EV_NADA, 0, 0);
      agregar(1, 4'hA, EV_MON, 0, 0);
    end
    agregar(1, 4'h8, EV_NADA, 0, 0);
    agregar(1, 4'h8, EV_NADA, 0, 0);
    agregar(1, 4'hB, EV_NADA, 0, 0);
    agregar(1, 4'h3, EV_NADA, 0, 0);
    agregar(1, 4'hA, EV_MON, 3, 0);

    // Reset state
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_digito", {28'b0, digito}, 0);
    check("rst_digito_stb", {31'b0, digito_stb}, 0);
    check("rst_monto", monto, 0);
    check("rst_monto_stb", {31'b0, monto_stb}, 0);
    check("rst_desborde", {31'b0, desborde}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press of 7: strobe exactly after the 7th edge counting the first sampling edge as 1.
    esperar(1'b0, 7);
    tecla_codigo = 4'h7;
    tecla_activa = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 6) check("lat_before", {31'b0, digito_stb}, 0);
      if (i == 7) begin
        check("lat_stb", {31'b0, digito_stb}, 1);
        check("lat_digito", {28'b0, digito}, 7);
      end
      if (i == 8) check("lat_after", {31'b0, digito_stb}, 0);
    end
    @(negedge clk);
    tecla_activa = 1'b0;
    repeat (D + 8) @(negedge clk);
    check("t1_pending", sb.size(), 0);

    // Short glitches then a stable press of 3, with a bouncy release.
    tecla_codigo = 4'h3;
    for (int r = 0; r < 3; r++) begin
      tecla_activa = 1'b1;
      repeat (2) @(negedge clk);
      tecla_activa = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("t2_glitch_digito", {28'b0, digito}, 7);
    esperar(1'b0, 3);
    tecla_activa = 1'b1;
    repeat (D + 8) @(negedge clk);
    for (int r = 0; r < 6; r++) begin
      tecla_activa = ~tecla_activa;
      @(negedge clk);
    end
    tecla_activa = 1'b0;
    repeat (D + 8) @(negedge clk);
    check("t2_digito", {28'b0, digito}, 3);
    check("t2_pending", sb.size(), 0);

    // Mode change coinciding with a key acceptance clears acc and drops the key.
    modo_monto = 1'b1;
    repeat (3) @(negedge clk);
    pulsar(4'h5);
    tecla_codigo = 4'h1;
    tecla_activa = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 6) modo_monto = 1'b0;
      if (i == 7) check("t5_dropped_key", {31'b0, digito_stb}, 0);
    end
    repeat (D + 4) @(negedge clk);
    tecla_activa = 1'b0;
    repeat (D + 8) @(negedge clk);
    modo_monto = 1'b1;
    repeat (3) @(negedge clk);
    esperar(1'b1, 0);
    pulsar(4'hA);
    check("t5_monto", monto, 0);
    check("t5_pending", sb.size(), 0);

    // Table-driven key events
    foreach (tabla[i]) begin
      if (modo_monto != tabla[i].modo) begin
        modo_monto = tabla[i].modo;
        repeat (3) @(negedge clk);
      end
      if (tabla[i].ev != EV_NADA) esperar(tabla[i].ev == EV_MON, tabla[i].valor);
      pulsar(tabla[i].cod);
      check($sformatf("vec%0d_desborde", i), {31'b0, desborde}, {31'b0, tabla[i].desb});
      check($sformatf("vec%0d_pending", i), sb.size(), 0);
    end
    check("hold_monto", monto, 3);
    check("hold_digito", {28'b0, digito}, 2);

    // Reset in the middle of filtering a held 9; the held key is then accepted once.
    modo_monto = 1'b0;
    repeat (3) @(negedge clk);
    tecla_codigo = 4'h9;
    tecla_activa = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_digito", {28'b0, digito}, 0);
    check("t6_rst_monto", monto, 0);
    check("t6_rst_desborde", {31'b0, desborde}, 0);
    check("t6_rst_stb", {30'b0, digito_stb, monto_stb}, 0);
    repeat (3) @(negedge clk);
    esperar(1'b0, 9);
    reset = 1'b0;
    repeat (D + 20) @(negedge clk);
    check("t6_digito", {28'b0, digito}, 9);
    tecla_activa = 1'b0;
    repeat (D + 8) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
